detect_window_counter: RTL and testbench
========================================

# detect_window_counter

- Downstream consumer of the serial sequence detector's one-cycle `detector_out` pulse.
- Counts detections over a programmable window of clock cycles, latches the result with saturation and threshold flags, and presents it to a control/status consumer over a valid/ack handshake.
- Windows repeat back-to-back while enabled.

## Interface
- `CNT_W`, default 8: width of the detection count.
- `WIN_W`, default 16: width of the window length.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `detector_in`  in  1  detection pulse from the detector stage; each high cycle is one detection.
- `enable`  in  1  run windows while high.
- `window_len`  in  WIN_W  window length in cycles; 0 is treated as 1.
- `threshold`  in  CNT_W  alarm level; 0 disables the alarm.
- `result_ack`  in  1  consumer accepts the result.
- `count_out`  out  CNT_W  latched final count.
- `count_valid`  out  1  result available.
- `overflow`  out  1  window count saturated.
- `alarm`  out  1  final count >= threshold (threshold != 0).
- `missed`  out  1  sticky: a detection arrived while in REPORT.
- `window_busy`  out  1  high in COUNT.

## Operation
- States: IDLE, COUNT, REPORT. Reset state is IDLE.
- Reset: all outputs 0; the running count, timer and sat flag are cleared. Reset mid-window discards all partial results.
- IDLE, `enable`=1 sampled:
  - Capture `max(window_len,1)` into the timer.
  - Clear the running count and sat flag.
  - Go to COUNT. The window's first cycle is the next cycle.
  - Detections in IDLE are ignored and do not set `missed`.
- COUNT, each cycle:
  - If `detector_in`=1, increment the running count, saturating at 2^CNT_W-1. An increment attempted at max sets sat.
  - Decrement the timer.
  - `window_len` and `threshold` changes during COUNT are ignored until the next window start (threshold is captured at window start).
- COUNT, last window cycle (timer reaches its final count):
  - Final count = running count plus this cycle's detection, saturating.
  - Latch final count into `count_out`.
  - Set `overflow` = sat (including sat from this last cycle).
  - Set `alarm` = (threshold != 0 && final >= threshold).
  - Assert `count_valid`.
  - Go to REPORT.
- COUNT with `enable`=0 sampled: abort and go to IDLE next cycle. No result is produced; `count_out`, `overflow` and `alarm` keep their previous values and `count_valid` stays 0.
- REPORT:
  - Outputs are held stable until `result_ack`=1 is sampled.
  - Any `detector_in`=1 sets `missed`; this includes the ack cycle.
  - On ack with `enable`=1: clear `count_valid`, restart the timer from current `window_len`, clear the count, go to COUNT.
  - On ack with `enable`=0: clear `count_valid`, go to IDLE.
  - `enable` falling in REPORT does not drop the result; it waits for ack.
- `missed` clears when the next result is latched (it is not re-evaluated in COUNT).
- `result_ack` outside REPORT is ignored.

## Timing
- Window of N cycles: detections sampled on exactly N consecutive edges, starting the edge after `enable` is sampled in IDLE, or after ack in REPORT.
- `count_valid` rises on the edge that samples the last window cycle; the result is visible the following cycle. Latency from the last counted detection to valid is 1 cycle.
- Ack may arrive in the first `count_valid` cycle. `count_valid` then falls at the next edge, so the minimum valid width is 1 cycle.
- Continuous operation with ack held high: period = N+1 cycles (N counting plus 1 REPORT). Detections in the REPORT cycle are lost and flagged by `missed`.
- `window_busy` is registered and equals (state==COUNT).
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Basic count with the 1011 detector upstream:
  - Setup: `window_len`=40, serial stream 1011011 fed to the detector.
  - Required: `count_out`=2, `count_valid` 1 cycle after window end, `overflow`=0, `alarm`=0 with threshold 0.
- Saturation:
  - Setup: CNT_W=8, `detector_in` held 1, `window_len`=300.
  - Required: `count_out`=255, `overflow`=1.
  - Then a window of 10 with no detections gives `count_out`=0, `overflow`=0.
- Alarm boundary:
  - Threshold=3 with 3 detections: `alarm`=1.
  - Threshold=4 with 3 detections: `alarm`=0.
  - Threshold=0 with 255 detections: `alarm`=0.
- Abort and reset:
  - `enable` dropped at cycle 5 of 20: IDLE next cycle, `count_valid` never rises, previous `count_out` retained.
  - Reset at cycle 7 of a window: all outputs 0 and IDLE on the next cycle.
- Handshake and continuous mode:
  - Delay ack by 4 cycles while pulsing `detector_in` twice: `count_valid` held for 4 cycles, `missed`=1, count unchanged.
  - Then ack held high with `window_len`=5: valid every 6 cycles, and `missed` clears at the next latch.
- `window_len`=0: behaves as 1.
  - A detection in that single cycle gives `count_out`=1.

Source files
------------

// File: rtl/detect_window_counter.sv
// Counts one-cycle detection pulses over a programmable window, latches the
// saturated result with overflow/alarm flags and holds it on a valid/ack
// handshake until the consumer takes it. Windows repeat while enable is high.
module detect_window_counter #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             detector_in,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic [CNT_W-1:0] threshold,
    input  logic             result_ack,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             alarm,
    output logic             missed,
    output logic             window_busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StReport
    } state_e;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [WIN_W-1:0] TimeOne = WIN_W'(1);

    state_e           state_q, state_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] count_out_q, count_out_d;
    logic             count_valid_q, count_valid_d;
    logic             overflow_q, overflow_d;
    logic             alarm_q, alarm_d;
    logic             missed_q, missed_d;
    logic             busy_q, busy_d;

    logic [WIN_W-1:0] win_len_eff;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    // Next-state logic: window start, per-cycle counting, result latch and handshake.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cnt_d         = cnt_q;
        sat_d         = sat_q;
        thr_d         = thr_q;
        count_out_d   = count_out_q;
        count_valid_d = count_valid_q;
        overflow_d    = overflow_q;
        alarm_d       = alarm_q;
        missed_d      = missed_q;

        // A zero-length window runs for one cycle.
        win_len_eff = (window_len == '0) ? TimeOne : window_len;

        // Count including this cycle's detection, saturating; an increment
        // attempted at the maximum is what marks saturation.
        cnt_next = cnt_q;
        sat_next = sat_q;
        if (detector_in) begin
            if (cnt_q == CntMax) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CntOne;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    timer_d = win_len_eff;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    thr_d   = threshold;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (!enable) begin
                    // Abort: partial count is dropped, previous result is kept.
                    state_d = StIdle;
                end else if (timer_q == TimeOne) begin
                    cnt_d         = cnt_next;
                    sat_d         = sat_next;
                    count_out_d   = cnt_next;
                    overflow_d    = sat_next;
                    alarm_d       = (thr_q != '0) && (cnt_next >= thr_q);
                    count_valid_d = 1'b1;
                    missed_d      = 1'b0;
                    state_d       = StReport;
                end else begin
                    cnt_d   = cnt_next;
                    sat_d   = sat_next;
                    timer_d = timer_q - TimeOne;
                end
            end
            StReport: begin
                if (detector_in) begin
                    missed_d = 1'b1;
                end
                if (result_ack) begin
                    count_valid_d = 1'b0;
                    if (enable) begin
                        timer_d = win_len_eff;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        thr_d   = threshold;
                        state_d = StCount;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StCount);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            cnt_q         <= '0;
            sat_q         <= 1'b0;
            thr_q         <= '0;
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            alarm_q       <= 1'b0;
            missed_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            sat_q         <= sat_d;
            thr_q         <= thr_d;
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
            overflow_q    <= overflow_d;
            alarm_q       <= alarm_d;
            missed_q      <= missed_d;
            busy_q        <= busy_d;
        end
    end

    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;
    assign overflow    = overflow_q;
    assign alarm       = alarm_q;
    assign missed      = missed_q;
    assign window_busy = busy_q;

endmodule

// File: tb/tb_detect_window_counter.sv
// Directed bench for detect_window_counter: a table of complete windows plus
// hand-written sequences for abort, reset, delayed ack and continuous mode.
module tb_detect_window_counter;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned WIN_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             detector_in;
    logic             enable;
    logic [WIN_W-1:0] window_len;
    logic [CNT_W-1:0] threshold;
    logic             result_ack;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             overflow;
    logic             alarm;
    logic             missed;
    logic             window_busy;

    int n_cmp = 0;
    int n_bad = 0;

    detect_window_counter #(
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .detector_in (detector_in),
        .enable      (enable),
        .window_len  (window_len),
        .threshold   (threshold),
        .result_ack  (result_ack),
        .count_out   (count_out),
        .count_valid (count_valid),
        .overflow    (overflow),
        .alarm       (alarm),
        .missed      (missed),
        .window_busy (window_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int wl;
        int thr;
        int ndet;
        int exp_cnt;
        int exp_ov;
        int exp_al;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One full window from IDLE, detections in the first ndet cycles, then ack to IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        n = (v.wl == 0) ? 1 : v.wl;
        enable      = 1'b1;
        window_len  = WIN_W'(v.wl);
        threshold   = CNT_W'(v.thr);
        detector_in = 1'b0;
        result_ack  = 1'b0;
        step();
        check($sformatf("v%0d_start_busy", idx), window_busy, 1);
        check($sformatf("v%0d_start_valid", idx), count_valid, 0);
        for (int i = 0; i < n; i++) begin
            detector_in = (i < v.ndet);
            if (i > 0 && i == n - 1) begin
                check($sformatf("v%0d_early_valid", idx), count_valid, 0);
            end
            step();
        end
        detector_in = 1'b0;
        check($sformatf("v%0d_valid", idx), count_valid, 1);
        check($sformatf("v%0d_busy", idx), window_busy, 0);
        check($sformatf("v%0d_count", idx), count_out, v.exp_cnt);
        check($sformatf("v%0d_overflow", idx), overflow, v.exp_ov);
        check($sformatf("v%0d_alarm", idx), alarm, v.exp_al);
        check($sformatf("v%0d_missed", idx), missed, 0);
        result_ack = 1'b1;
        enable     = 1'b0;
        step();
        result_ack = 1'b0;
        check($sformatf("v%0d_ack_valid", idx), count_valid, 0);
        check($sformatf("v%0d_ack_busy", idx), window_busy, 0);
    endtask

    initial begin
        logic [3:0] sr;
        logic [6:0] stream;
        logic       det;

        //          wl   thr  ndet cnt  ov al
        vecs[0] = '{10,  0,   0,   0,   0, 0};
        vecs[1] = '{10,  3,   3,   3,   0, 1};
        vecs[2] = '{10,  4,   3,   3,   0, 0};
        vecs[3] = '{300, 0,   300, 255, 1, 0};
        vecs[4] = '{10,  0,   0,   0,   0, 0};
        vecs[5] = '{255, 0,   255, 255, 0, 0};
        vecs[6] = '{256, 255, 256, 255, 1, 1};
        vecs[7] = '{0,   1,   1,   1,   0, 1};
        vecs[8] = '{1,   0,   0,   0,   0, 0};
        vecs[9] = '{5,   5,   5,   5,   0, 1};

        reset       = 1'b1;
        detector_in = 1'b0;
        enable      = 1'b0;
        window_len  = '0;
        threshold   = '0;
        result_ack  = 1'b0;
        step();
        step();
        check("rst_count", count_out, 0);
        check("rst_valid", count_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_alarm", alarm, 0);
        check("rst_missed", missed, 0);
        check("rst_busy", window_busy, 0);
        reset = 1'b0;

        // Detections in IDLE are ignored.
        detector_in = 1'b1;
        step();
        detector_in = 1'b0;
        check("idle_missed", missed, 0);

        // 1011 overlapping detector upstream on stream 1011011: two detections.
        stream      = 7'b1011011;
        sr          = '0;
        enable      = 1'b1;
        window_len  = 16'd40;
        threshold   = '0;
        step();
        for (int i = 0; i < 40; i++) begin
            if (i < 7) begin
                sr  = {sr[2:0], stream[6 - i]};
                det = (sr == 4'b1011);
            end else begin
                det = 1'b0;
            end
            detector_in = det;
            if (i == 39) begin
                check("seq_early_valid", count_valid, 0);
            end
            step();
        end
        detector_in = 1'b0;
        check("seq_valid", count_valid, 1);
        check("seq_count", count_out, 2);
        check("seq_overflow", overflow, 0);
        check("seq_alarm", alarm, 0);
        result_ack = 1'b1;
        enable     = 1'b0;
        step();
        result_ack = 1'b0;

        for (int v = 0; v < 10; v++) begin
            run_vec(v, vecs[v]);
        end

        // Abort at cycle 5 of 20: previous result (5, alarm) is retained.
        enable     = 1'b1;
        window_len = 16'd20;
        threshold  = '0;
        step();
        for (int i = 1; i <= 4; i++) begin
            detector_in = 1'b1;
            step();
            check("abort_busy_run", window_busy, 1);
        end
        enable = 1'b0;
        step();
        detector_in = 1'b0;
        check("abort_busy", window_busy, 0);
        check("abort_valid", count_valid, 0);
        check("abort_count", count_out, 5);
        check("abort_alarm", alarm, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_valid_hold", count_valid, 0);
        end

        // Delayed ack with detections in REPORT.
        enable     = 1'b1;
        window_len = 16'd6;
        threshold  = 8'd2;
        step();
        for (int i = 0; i < 6; i++) begin
            detector_in = (i < 2);
            step();
        end
        detector_in = 1'b0;
        check("hs_valid", count_valid, 1);
        check("hs_count", count_out, 2);
        check("hs_alarm", alarm, 1);
        check("hs_missed0", missed, 0);
        for (int j = 0; j < 4; j++) begin
            detector_in = (j == 1 || j == 3);
            step();
            check("hs_hold_valid", count_valid, 1);
            check("hs_hold_count", count_out, 2);
            check("hs_hold_busy", window_busy, 0);
            check("hs_missed", missed, (j >= 1) ? 1 : 0);
        end
        detector_in = 1'b0;
        result_ack  = 1'b1;
        window_len  = 16'd20;
        step();
        result_ack = 1'b0;
        check("hs_ack_valid", count_valid, 0);
        check("hs_ack_busy", window_busy, 1);
        check("hs_ack_missed", missed, 1);
        check("hs_ack_count", count_out, 2);

        // Reset at cycle 7 of the new window.
        for (int i = 1; i <= 6; i++) begin
            detector_in = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        reset       = 1'b0;
        detector_in = 1'b0;
        check("mrst_count", count_out, 0);
        check("mrst_valid", count_valid, 0);
        check("mrst_overflow", overflow, 0);
        check("mrst_alarm", alarm, 0);
        check("mrst_missed", missed, 0);
        check("mrst_busy", window_busy, 0);
        enable = 1'b0;
        step();
        check("mrst_idle_busy", window_busy, 0);

        // Continuous mode: ack held high, window 5 -> period 6.
        enable     = 1'b1;
        result_ack = 1'b1;
        window_len = 16'd5;
        threshold  = '0;
        step();
        check("cont_start_busy", window_busy, 1);
        for (int k = 1; k <= 17; k++) begin
            detector_in = (k == 2 || k == 6 || k == 8 || k == 9);
            step();
            check($sformatf("cont_valid_k%0d", k), count_valid, (k % 6 == 5) ? 1 : 0);
            check($sformatf("cont_busy_k%0d", k), window_busy, (k % 6 != 5) ? 1 : 0);
            if (k == 5) begin
                check("cont_count_w1", count_out, 1);
                check("cont_missed_w1", missed, 0);
            end
            if (k == 6) begin
                check("cont_missed_set", missed, 1);
            end
            if (k == 11) begin
                check("cont_count_w2", count_out, 2);
                check("cont_missed_clr", missed, 0);
            end
            if (k == 17) begin
                check("cont_count_w3", count_out, 0);
                check("cont_missed_w3", missed, 0);
            end
        end
        detector_in = 1'b0;
        enable      = 1'b0;
        step();
        result_ack = 1'b0;
        check("cont_end_valid", count_valid, 0);
        check("cont_end_busy", window_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
